mc_mem_unit: RTL and testbench

//   Parametrised multi-port memory unit for the multicycle RISC core, successor to the single-port 1-cycle memory.
//   NUM_PORTS requestors (e.g. fetch, load/store, DMA) share one word-addressed RAM through round-robin arbitration.

---
 rtl/mc_mem_pkg.sv | 15 +
 rtl/mc_mem_rr_arbiter.sv | 27 ++
 rtl/mc_mem_unit.sv | 127 ++++++++++++
 tb/tb_mc_mem_unit.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/mc_mem_pkg.sv
// Shared types and constants for the multi-port memory unit.
package mc_mem_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 6;

  // Width needed to hold values 0..v-1, never less than one bit.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction
endpackage

// File: rtl/mc_mem_rr_arbiter.sv
// Round-robin arbiter: search starts one past ptr and wraps; first asserted req wins.
module rr_arbiter
  import mc_mem_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);
  logic found;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 1; i <= N; i++) begin
      if (!found && req[(int'(ptr) + i) % N]) begin
        found                      = 1'b1;
        grant[(int'(ptr) + i) % N] = 1'b1;
        idx                        = IW'((int'(ptr) + i) % N);
      end
    end
  end
endmodule

// File: rtl/mc_mem_unit.sv
// Multi-port word RAM with round-robin arbitration and configurable access latency.
module mc_mem_unit
  import mc_mem_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int NUM_PORTS = 2,
  parameter int LATENCY   = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_PORTS-1:0]        req,
  input  logic [NUM_PORTS-1:0]        we,
  input  logic [NUM_PORTS*ADDR_W-1:0] addr,
  input  logic [NUM_PORTS*DATA_W-1:0] wdata,
  output logic [NUM_PORTS-1:0]        gnt,
  output logic [NUM_PORTS-1:0]        done,
  output logic [DATA_W-1:0]           rdata,
  output logic                        busy
);
  localparam int IDW   = clog2(NUM_PORTS);
  localparam int CW    = clog2(LATENCY);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  state_t                 state_q, state_d;
  logic [IDW-1:0]         id_q, id_d, ptr_q, ptr_d, arb_idx;
  logic                   we_q, we_d, mem_we;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [DATA_W-1:0]      wdata_q, wdata_d, rdata_q, rdata_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [NUM_PORTS-1:0]   gnt_q, gnt_d, done_q, done_d, arb_grant;
  logic                   busy_q, busy_d;

  rr_arbiter #(.N(NUM_PORTS), .IW(IDW)) u_arb (
    .req   (req),
    .ptr   (ptr_q),
    .grant (arb_grant),
    .idx   (arb_idx)
  );

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    done_d  = done_q;
    rdata_d = rdata_q;
    busy_d  = busy_q;
    mem_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = ACCESS;
          id_d    = arb_idx;
          we_d    = we[arb_idx];
          addr_d  = addr[int'(arb_idx)*ADDR_W +: ADDR_W];
          wdata_d = wdata[int'(arb_idx)*DATA_W +: DATA_W];
          cnt_d   = CW'(LATENCY - 1);
          gnt_d   = arb_grant;
          busy_d  = 1'b1;
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          state_d = RESP;
          gnt_d   = '0;
          done_d  = gnt_q;  // gnt_q is already one-hot on the served port
          mem_we  = we_q;
          rdata_d = we_q ? wdata_q : mem[addr_q];
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
        done_d  = '0;
        busy_d  = 1'b0;
        ptr_d   = id_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      id_q    <= '0;
      ptr_q   <= IDW'(NUM_PORTS - 1);
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      rdata_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      rdata_q <= rdata_d;
      busy_q  <= busy_d;
    end
  end

  // RAM has no reset; a reset on the commit edge drops the pending write.
  always_ff @(posedge clk) begin
    if (!rst && mem_we) mem[addr_q] <= wdata_q;
  end

  assign gnt   = gnt_q;
  assign done  = done_q;
  assign rdata = rdata_q;
  assign busy  = busy_q;
endmodule

// File: tb/tb_mc_mem_unit.sv
// Directed bench: three instances (2 ports/lat 1, 2 ports/lat 3, 4 ports/lat 1) driven one at a time.
module tb_mc_mem_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int sel = 0;
  logic [3:0]       req_c = '0, we_c = '0;
  logic [3:0][5:0]  addr_c = '0;
  logic [3:0][15:0] wdata_c = '0;

  logic [1:0] req0, we0, gnt0, done0, req1, we1, gnt1, done1;
  logic [3:0] req2, we2, gnt2, done2;
  logic [11:0] addr0, addr1;
  logic [23:0] addr2;
  logic [31:0] wdata0, wdata1;
  logic [63:0] wdata2;
  logic [15:0] rdata0, rdata1, rdata2;
  logic busy0, busy1, busy2;

  assign req0   = (sel == 0) ? req_c[1:0]   : '0;
  assign we0    = (sel == 0) ? we_c[1:0]    : '0;
  assign addr0  = (sel == 0) ? addr_c[1:0]  : '0;
  assign wdata0 = (sel == 0) ? wdata_c[1:0] : '0;
  assign req1   = (sel == 1) ? req_c[1:0]   : '0;
  assign we1    = (sel == 1) ? we_c[1:0]    : '0;
  assign addr1  = (sel == 1) ? addr_c[1:0]  : '0;
  assign wdata1 = (sel == 1) ? wdata_c[1:0] : '0;
  assign req2   = (sel == 2) ? req_c        : '0;
  assign we2    = (sel == 2) ? we_c         : '0;
  assign addr2  = (sel == 2) ? addr_c       : '0;
  assign wdata2 = (sel == 2) ? wdata_c      : '0;

  mc_mem_unit #(.DATA_W(16), .ADDR_W(6), .NUM_PORTS(2), .LATENCY(1)) dut0 (
    .clk(clk), .rst(rst), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
    .gnt(gnt0), .done(done0), .rdata(rdata0), .busy(busy0));
  mc_mem_unit #(.DATA_W(16), .ADDR_W(6), .NUM_PORTS(2), .LATENCY(3)) dut1 (
    .clk(clk), .rst(rst), .req(req1), .we(we1), .addr(addr1), .wdata(wdata1),
    .gnt(gnt1), .done(done1), .rdata(rdata1), .busy(busy1));
  mc_mem_unit #(.DATA_W(16), .ADDR_W(6), .NUM_PORTS(4), .LATENCY(1)) dut2 (
    .clk(clk), .rst(rst), .req(req2), .we(we2), .addr(addr2), .wdata(wdata2),
    .gnt(gnt2), .done(done2), .rdata(rdata2), .busy(busy2));

  logic [3:0]  gnt_s, done_s;
  logic [15:0] rdata_s;
  logic        busy_s;
  always_comb begin
    case (sel)
      0:       begin gnt_s = {2'b0, gnt0}; done_s = {2'b0, done0}; rdata_s = rdata0; busy_s = busy0; end
      1:       begin gnt_s = {2'b0, gnt1}; done_s = {2'b0, done1}; rdata_s = rdata1; busy_s = busy1; end
      default: begin gnt_s = gnt2;         done_s = done2;         rdata_s = rdata2; busy_s = busy2; end
    endcase
  end

  int checks = 0, failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // One isolated transfer on the selected instance, checking every cycle of it.
  task automatic txn(input int p, input logic w, input logic [5:0] a, input logic [15:0] d,
                     input logic [15:0] exp, input string nm);
    int lat;
    logic [3:0] oh;
    lat = (sel == 1) ? 3 : 1;
    oh  = 4'b1 << p;
    @(posedge clk); #1;
    req_c[p] = 1'b1; we_c[p] = w; addr_c[p] = a; wdata_c[p] = d;
    @(negedge clk);
    chk({nm, ".idle_gnt"}, 32'(gnt_s), 32'h0);
    chk({nm, ".idle_busy"}, 32'(busy_s), 32'h0);
    for (int k = 0; k < lat; k++) begin
      @(negedge clk);
      chk({nm, ".gnt"}, 32'(gnt_s), 32'(oh));
      chk({nm, ".acc_done"}, 32'(done_s), 32'h0);
      chk({nm, ".acc_busy"}, 32'(busy_s), 32'h1);
    end
    @(negedge clk);
    chk({nm, ".done"}, 32'(done_s), 32'(oh));
    chk({nm, ".rdata"}, 32'(rdata_s), 32'(exp));
    chk({nm, ".resp_busy"}, 32'(busy_s), 32'h1);
    chk({nm, ".resp_gnt"}, 32'(gnt_s), 32'h0);
    req_c[p] = 1'b0;
    @(negedge clk);
    chk({nm, ".after_done"}, 32'(done_s), 32'h0);
    chk({nm, ".after_busy"}, 32'(busy_s), 32'h0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  typedef struct {
    int          port;
    logic        we;
    logic [5:0]  addr;
    logic [15:0] wdata;
    logic [15:0] exp;
  } vec_t;
  vec_t vecs[7];

  initial begin
    logic [3:0] dlog [12];
    logic [3:0] glog [12];
    logic [15:0] rlog [12];
    logic [3:0] e_gnt [7];
    logic [3:0] e_done [7];
    logic e_busy [7];

    vecs[0] = '{0, 1'b1, 6'd5,  16'hBEEF, 16'hBEEF};
    vecs[1] = '{0, 1'b0, 6'd5,  16'h0000, 16'hBEEF};
    vecs[2] = '{1, 1'b1, 6'd63, 16'h1234, 16'h1234};
    vecs[3] = '{1, 1'b0, 6'd5,  16'h0000, 16'hBEEF};
    vecs[4] = '{0, 1'b1, 6'd0,  16'h0001, 16'h0001};
    vecs[5] = '{1, 1'b0, 6'd63, 16'hFFFF, 16'h1234};
    vecs[6] = '{0, 1'b0, 6'd0,  16'h0000, 16'h0001};

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      chk($sformatf("reset%0d.gnt", s), 32'(gnt_s), 32'h0);
      chk($sformatf("reset%0d.done", s), 32'(done_s), 32'h0);
      chk($sformatf("reset%0d.rdata", s), 32'(rdata_s), 32'h0);
      chk($sformatf("reset%0d.busy", s), 32'(busy_s), 32'h0);
    end

    sel = 0;
    for (int i = 0; i < 7; i++)
      txn(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp, $sformatf("vec%0d", i));

    // Both ports requesting continuously from reset: 0,1,0,1 with dones 3 cycles apart.
    do_reset();
    req_c = 4'b0011; we_c = '0; addr_c[0] = 6'd5; addr_c[1] = 6'd63;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      dlog[c] = done_s; glog[c] = gnt_s; rlog[c] = rdata_s;
    end
    req_c = '0;
    for (int c = 0; c < 12; c++) begin
      if (c % 3 == 1) chk($sformatf("rr.gnt%0d", c), 32'(glog[c]), (c % 6 == 1) ? 32'h1 : 32'h2);
      else            chk($sformatf("rr.gnt%0d", c), 32'(glog[c]), 32'h0);
      if (c % 3 == 2) begin
        chk($sformatf("rr.done%0d", c), 32'(dlog[c]), (c % 6 == 2) ? 32'h1 : 32'h2);
        chk($sformatf("rr.rdata%0d", c), 32'(rlog[c]), (c % 6 == 2) ? 32'hBEEF : 32'h1234);
      end else begin
        chk($sformatf("rr.done%0d", c), 32'(dlog[c]), 32'h0);
      end
    end
    repeat (2) @(negedge clk);

    // Reset on the commit edge of a write must drop it.
    txn(0, 1'b1, 6'd2, 16'hAAAA, 16'hAAAA, "pre_wr");
    @(posedge clk); #1;
    req_c[0] = 1'b1; we_c[0] = 1'b1; addr_c[0] = 6'd2; wdata_c[0] = 16'h5555;
    @(posedge clk); #1;
    chk("rst_mid.gnt_before", 32'(gnt_s), 32'h1);
    rst = 1'b1; req_c = '0;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_mid.gnt", 32'(gnt_s), 32'h0);
    chk("rst_mid.done", 32'(done_s), 32'h0);
    chk("rst_mid.rdata", 32'(rdata_s), 32'h0);
    chk("rst_mid.busy", 32'(busy_s), 32'h0);
    txn(0, 1'b0, 6'd2, 16'h0000, 16'hAAAA, "rst_mid.readback");

    // LATENCY=3: write then read top address.
    sel = 1;
    txn(0, 1'b1, 6'd63, 16'h1234, 16'h1234, "lat3.wr");
    txn(1, 1'b0, 6'd63, 16'h0000, 16'h1234, "lat3.rd");
    txn(0, 1'b1, 6'd2, 16'h00AA, 16'h00AA, "lat3.wr2");

    // Request dropped and address changed after acceptance; latched values still used.
    @(posedge clk); #1;
    req_c[0] = 1'b1; we_c[0] = 1'b0; addr_c[0] = 6'd63;
    @(posedge clk); #1;
    req_c[0] = 1'b0; addr_c[0] = 6'd2;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("drop.gnt%0d", k), 32'(gnt_s), 32'h1);
    end
    @(negedge clk);
    chk("drop.done", 32'(done_s), 32'h1);
    chk("drop.rdata", 32'(rdata_s), 32'h1234);
    @(negedge clk);
    chk("drop.idle_done", 32'(done_s), 32'h0);

    // Four ports, pointer at 1: port 3 beats port 1.
    sel = 2;
    txn(1, 1'b1, 6'd10, 16'h0111, 16'h0111, "p4.setup");
    e_gnt  = '{4'h0, 4'h8, 4'h0, 4'h0, 4'h2, 4'h0, 4'h0};
    e_done = '{4'h0, 4'h0, 4'h8, 4'h0, 4'h0, 4'h2, 4'h0};
    e_busy = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    @(posedge clk); #1;
    req_c = 4'b1010;
    we_c[3] = 1'b1; addr_c[3] = 6'd10; wdata_c[3] = 16'h0333;
    we_c[1] = 1'b0; addr_c[1] = 6'd10;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      chk($sformatf("p4.gnt%0d", c), 32'(gnt_s), 32'(e_gnt[c]));
      chk($sformatf("p4.done%0d", c), 32'(done_s), 32'(e_done[c]));
      chk($sformatf("p4.busy%0d", c), 32'(busy_s), 32'(e_busy[c]));
      if (c == 2) begin
        chk("p4.rdata_wr", 32'(rdata_s), 32'h0333);
        req_c[3] = 1'b0;
      end
      if (c == 5) begin
        chk("p4.rdata_rd", 32'(rdata_s), 32'h0333);
        req_c[1] = 1'b0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
